operand_fetch_stage: RTL and testbench
======================================

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001 SHALL have clk, input, 1, sole clock, all state on rising edge.
REQ-002 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have in_valid/in_ready, input/output, 1 each, upstream decode handshake.
REQ-004 SHALL have ra1, ra2, input, 5 each, source register numbers offered with in_valid.
REQ-005 SHALL have rf_ra1, rf_ra2, output, 5 each, read addresses driven to the synchronous-read register file.
REQ-006 SHALL have rf_rd1, rf_rd2, input, 32 each, register file read data, valid one cycle after rf_ra*.
REQ-007 SHALL have we, wa (5), wd (32), inputs, the writeback port, also wired to the register file.
REQ-008 SHALL have ex_we, ex_wa (5), ex_wd (32), inputs, EX-stage result for forwarding.
REQ-009 SHALL have flush, input, 1, synchronous pipeline kill.
REQ-010 SHALL have out_valid/out_ready, output/input, 1 each, downstream EX handshake.
REQ-011 SHALL have op_a, op_b (32 each), out_ra1, out_ra2 (5 each), outputs, resolved operands and their register numbers.

Function
REQ-012 SHALL contain two stages: S1 (address issued, awaiting rf_rd) and OUT (output register); valid bits s1_v, out_v.
REQ-013 SHALL define adv = !out_v || out_ready; in_ready = !s1_v || adv, combinational.
REQ-014 SHALL accept an entry when in_valid && in_ready && !flush, latching ra1/ra2 into S1 and setting s1_v.
REQ-015 SHALL drive rf_ra* = ra* when accepting, else the S1 addresses, so a stalled S1 entry is re-read every cycle.
REQ-016 SHALL, per source each cycle, set a hazard flag and latch wd when we && wa == rf_ra* && wa != 0 (register file returns stale data on same-cycle write); flag clears when no match in that cycle.
REQ-017 SHALL resolve each S1 operand with priority: register 0 -> 0; ex_we && ex_wa match -> ex_wd; we && wa match (current cycle) -> wd; hazard flag -> latched wd; else rf_rd*.
REQ-018 SHALL move S1 into OUT when s1_v && adv, loading op_a/op_b/out_ra*, setting out_v; S1 clears unless a new entry is accepted same edge.
REQ-019 SHALL hold OUT contents stable while out_v && !out_ready.
REQ-020 SHALL clear out_v when out_ready && !s1_v.
REQ-021 SHALL deliver a new entry on OUT 2 cycles after acceptance with no stall; full throughput 1 entry/cycle.
REQ-022 SHALL on flush clear s1_v, out_v and hazard flags at the edge; in_valid in the flush cycle is dropped.
REQ-023 SHALL keep in_ready high during flush so upstream is not stalled.

Reset
REQ-024 SHALL on rst_n low immediately clear s1_v, out_v, hazard flags, op_a, op_b, out_ra1, out_ra2 and S1 addresses to 0.
REQ-025 SHALL drive in_ready = 1 and rf_ra* = ra* while and after reset until the first accept.
REQ-026 SHALL discard any entry in flight when reset asserts mid-operation; no output after release without a new accept.

Configuration
REQ-027 SHALL honour macro EX_FWD_EN: defined -> EX forwarding per REQ-017; undefined -> ex_we/ex_wa/ex_wd ignored, priority skips that term, ports still present.

Verification
REQ-028 SHALL check: x5=0x11 in file, accept ra1=5 -> out_v with op_a=0x11 two cycles later.
REQ-029 SHALL check: accept ra1=7 while we=1,wa=7,wd=0xABCD same cycle -> op_a=0xABCD, not stale value.
REQ-030 SHALL check (EX_FWD_EN): S1 ra2=3, ex_we=1,ex_wa=3,ex_wd=0x55 and we=1,wa=3,wd=0x66 -> op_b=0x55; without macro -> 0x66.
REQ-031 SHALL check: out_ready=0 for 3 cycles with S1 full, wa=S1 ra1 written 0x99 mid-stall -> op_a=0x99 after release, in_ready=0 during stall, no entry lost or duplicated.
REQ-032 SHALL check: ra1=0 with we=1,wa=0,wd=0xFFFF -> op_a=0; flush with both stages full -> out_v=0 next cycle; rst_n low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: issues synchronous register-file reads and resolves
// writeback / EX bypasses into a two-deep valid/ready pipeline. Optional EX forwarding: EX_FWD_EN.
module operand_fetch_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [4:0]  rf_ra1,
    output logic [4:0]  rf_ra2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic        ex_we,
    input  logic [4:0]  ex_wa,
    input  logic [31:0] ex_wd,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [4:0]  out_ra1,
    output logic [4:0]  out_ra2
);

    logic        s1_v, out_v;
    logic [4:0]  s1_ra1, s1_ra2;
    logic        haz1, haz2;
    logic [31:0] hwd1, hwd2;
    logic        adv, accept, xfer;
    logic        ex_hit1, ex_hit2;
    logic [31:0] res1, res2;

    assign adv       = !out_v || out_ready;
    assign in_ready  = !s1_v || adv || flush;
    assign accept    = in_valid && in_ready && !flush;
    assign xfer      = s1_v && adv && !flush;
    assign out_valid = out_v;

    // An idle S1 also passes ra* through, so the read port tracks upstream after reset.
    assign rf_ra1 = (accept || !s1_v) ? ra1 : s1_ra1;
    assign rf_ra2 = (accept || !s1_v) ? ra2 : s1_ra2;

`ifdef EX_FWD_EN
    assign ex_hit1 = ex_we && (ex_wa == s1_ra1);
    assign ex_hit2 = ex_we && (ex_wa == s1_ra2);
`else
    logic unused_ex;
    assign unused_ex = ^{ex_we, ex_wa, ex_wd};
    assign ex_hit1   = 1'b0;
    assign ex_hit2   = 1'b0;
`endif

    always_comb begin
        res1 = rf_rd1;
        if (s1_ra1 == '0)                 res1 = '0;
        else if (ex_hit1)                 res1 = ex_wd;
        else if (we && (wa == s1_ra1))    res1 = wd;
        else if (haz1)                    res1 = hwd1;

        res2 = rf_rd2;
        if (s1_ra2 == '0)                 res2 = '0;
        else if (ex_hit2)                 res2 = ex_wd;
        else if (we && (wa == s1_ra2))    res2 = wd;
        else if (haz2)                    res2 = hwd2;
    end

    // The register file returns pre-write data when read and written in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            haz1 <= 1'b0;
            haz2 <= 1'b0;
            hwd1 <= '0;
            hwd2 <= '0;
        end else if (flush) begin
            haz1 <= 1'b0;
            haz2 <= 1'b0;
        end else begin
            haz1 <= we && (wa == rf_ra1) && (wa != '0);
            haz2 <= we && (wa == rf_ra2) && (wa != '0);
            if (we && (wa == rf_ra1)) hwd1 <= wd;
            if (we && (wa == rf_ra2)) hwd2 <= wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_ra1 <= '0;
            s1_ra2 <= '0;
        end else if (flush) begin
            s1_v <= 1'b0;
        end else if (accept) begin
            s1_v   <= 1'b1;
            s1_ra1 <= ra1;
            s1_ra2 <= ra2;
        end else if (xfer) begin
            s1_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v   <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            out_ra1 <= '0;
            out_ra2 <= '0;
        end else if (flush) begin
            out_v <= 1'b0;
        end else if (xfer) begin
            out_v   <= 1'b1;
            op_a    <= res1;
            op_b    <= res2;
            out_ra1 <= s1_ra1;
            out_ra2 <= s1_ra2;
        end else if (out_ready) begin
            out_v <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed vector table, reset corner cases and
// random traffic against an architectural-register reference model.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  ra1, ra2, rf_ra1, rf_ra2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ex_we;
    logic [4:0]  ex_wa;
    logic [31:0] ex_wd;
    logic        flush, out_valid, out_ready;
    logic [31:0] op_a, op_b;
    logic [4:0]  out_ra1, out_ra2;

    operand_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ra1(ra1), .ra2(ra2), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .we(we), .wa(wa), .wd(wd),
        .ex_we(ex_we), .ex_wa(ex_wa), .ex_wd(ex_wd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .op_a(op_a), .op_b(op_b),
        .out_ra1(out_ra1), .out_ra2(out_ra2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int unsigned i);
        case (i)
            3:       return 32'h33;
            5:       return 32'h11;
            7:       return 32'h77;
            default: return 32'h100 + i;
        endcase
    endfunction

    // Synchronous-read register file environment: reads return pre-write contents.
    logic        preload;
    logic [31:0] rf_mem [32];
    always @(posedge clk) begin
        rf_rd1 <= rf_mem[rf_ra1];
        rf_rd2 <= rf_mem[rf_ra2];
        if (preload) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
        end else if (we) begin
            rf_mem[wa] <= wd;
        end
    end

    typedef struct {
        bit          iv;
        logic [4:0]  a1, a2;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          xwe;
        logic [4:0]  xwa;
        logic [31:0] xwd;
        bit          ordy, fl;
        bit          chk, eir, eov;
        logic [31:0] ea, eb;
    } vec_t;

    function automatic vec_t mk(bit iv, logic [4:0] a1, logic [4:0] a2, bit w, logic [4:0] wadr,
                                logic [31:0] wdat, bit ordy, bit fl, bit chk, bit eir, bit eov,
                                logic [31:0] ea, logic [31:0] eb);
        vec_t v;
        v.iv = iv; v.a1 = a1; v.a2 = a2; v.we = w; v.wa = wadr; v.wd = wdat;
        v.xwe = 1'b0; v.xwa = '0; v.xwd = '0; v.ordy = ordy; v.fl = fl;
        v.chk = chk; v.eir = eir; v.eov = eov; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: pipeline occupancy from the handshake rules, operand values
    // from the architectural register contents at the moment of transfer.
    bit          ms1_v, mo_v;
    logic [4:0]  ms1_a1, ms1_a2, mo_r1, mo_r2;
    logic [31:0] mo_a, mo_b;
    logic [31:0] arch [32];

    function automatic logic [31:0] resolve(input logic [4:0] r);
        if (r == 0) return '0;
`ifdef EX_FWD_EN
        if (ex_we && ex_wa == r) return ex_wd;
`endif
        if (we && wa == r) return wd;
        return arch[r];
    endfunction

    task automatic apply(input vec_t v);
        in_valid = v.iv; ra1 = v.a1; ra2 = v.a2;
        we = v.we; wa = v.wa; wd = v.wd;
        ex_we = v.xwe; ex_wa = v.xwa; ex_wd = v.xwd;
        out_ready = v.ordy; flush = v.fl;
    endtask

    task automatic step(input bit tchk, input vec_t v);
        bit          adv, eir, acc, xf, c_we, c_or, c_fl;
        logic [4:0]  e1, e2, c_a1, c_a2, c_wa;
        logic [31:0] na, nb, c_wd;
        @(negedge clk);
        cyc++;
        adv = !mo_v || out_ready;
        eir = !ms1_v || adv || flush;
        acc = in_valid && eir && !flush;
        e1  = (acc || !ms1_v) ? ra1 : ms1_a1;
        e2  = (acc || !ms1_v) ? ra2 : ms1_a2;
        chk("in_ready", {31'b0, in_ready}, {31'b0, eir});
        chk("out_valid", {31'b0, out_valid}, {31'b0, mo_v});
        chk("rf_ra1", {27'b0, rf_ra1}, {27'b0, e1});
        chk("rf_ra2", {27'b0, rf_ra2}, {27'b0, e2});
        if (mo_v) begin
            chk("op_a", op_a, mo_a);
            chk("op_b", op_b, mo_b);
            chk("out_ra1", {27'b0, out_ra1}, {27'b0, mo_r1});
            chk("out_ra2", {27'b0, out_ra2}, {27'b0, mo_r2});
        end
        if (tchk && v.chk) begin
            chk("tbl_in_ready", {31'b0, in_ready}, {31'b0, v.eir});
            chk("tbl_out_valid", {31'b0, out_valid}, {31'b0, v.eov});
            if (v.eov) begin
                chk("tbl_op_a", op_a, v.ea);
                chk("tbl_op_b", op_b, v.eb);
            end
        end
        xf = ms1_v && adv && !flush;
        na = resolve(ms1_a1);
        nb = resolve(ms1_a2);
        c_a1 = ra1; c_a2 = ra2; c_we = we; c_wa = wa; c_wd = wd;
        c_or = out_ready; c_fl = flush;
        @(posedge clk);
        if (c_fl) begin
            ms1_v = 1'b0;
            mo_v  = 1'b0;
        end else begin
            if (xf) begin
                mo_v = 1'b1; mo_a = na; mo_b = nb; mo_r1 = ms1_a1; mo_r2 = ms1_a2;
            end else if (c_or) begin
                mo_v = 1'b0;
            end
            if (acc) begin
                ms1_v = 1'b1; ms1_a1 = c_a1; ms1_a2 = c_a2;
            end else if (xf) begin
                ms1_v = 1'b0;
            end
        end
        if (c_we) arch[c_wa] = c_wd;
        #1;
    endtask

    localparam logic [31:0] EXP_B_FWD =
`ifdef EX_FWD_EN
        32'h55;
`else
        32'h66;
`endif

    vec_t tbl [27];
    vec_t idle, rv;

    initial begin
        for (int i = 0; i < 32; i++) arch[i] = init_val(i);
        ms1_v = 1'b0; mo_v = 1'b0;
        ms1_a1 = '0; ms1_a2 = '0; mo_r1 = '0; mo_r2 = '0; mo_a = '0; mo_b = '0;
        idle = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        //        iv a1  a2  we wa  wd          ordy fl chk ir ov  op_a          op_b
        tbl[0]  = mk(1, 5,  6,  0, 0,  0,           1, 0, 1, 1, 0, 0,            0);
        tbl[1]  = mk(0, 0,  0,  0, 0,  0,           1, 0, 1, 1, 0, 0,            0);
        tbl[2]  = mk(0, 0,  0,  0, 0,  0,           1, 0, 1, 1, 1, 32'h11,       32'h106);
        tbl[3]  = mk(0, 0,  0,  0, 0,  0,           1, 0, 1, 1, 0, 0,            0);
        tbl[4]  = mk(1, 7,  0,  1, 7,  32'hABCD,    1, 0, 1, 1, 0, 0,            0);
        tbl[5]  = mk(0, 0,  0,  0, 0,  0,           1, 0, 0, 0, 0, 0,            0);
        tbl[6]  = mk(0, 0,  0,  0, 0,  0,           1, 0, 1, 1, 1, 32'hABCD,     0);
        tbl[7]  = mk(1, 1,  3,  0, 0,  0,           1, 0, 1, 1, 0, 0,            0);
        tbl[8]  = mk(0, 0,  0,  1, 3,  32'h66,      1, 0, 0, 0, 0, 0,            0);
        tbl[8].xwe = 1'b1; tbl[8].xwa = 5'd3; tbl[8].xwd = 32'h55;
        tbl[9]  = mk(0, 0,  0,  0, 0,  0,           1, 0, 1, 1, 1, 32'h101,      EXP_B_FWD);
        tbl[10] = mk(1, 9,  10, 0, 0,  0,           1, 0, 1, 1, 0, 0,            0);
        tbl[11] = mk(1, 11, 12, 0, 0,  0,           0, 0, 1, 1, 0, 0,            0);
        tbl[12] = mk(1, 13, 14, 0, 0,  0,           0, 0, 1, 0, 1, 32'h109,      32'h10A);
        tbl[13] = mk(1, 13, 14, 1, 11, 32'h99,      0, 0, 1, 0, 1, 32'h109,      32'h10A);
        tbl[14] = mk(1, 13, 14, 0, 0,  0,           0, 0, 1, 0, 1, 32'h109,      32'h10A);
        tbl[15] = mk(1, 13, 14, 0, 0,  0,           1, 0, 1, 1, 1, 32'h109,      32'h10A);
        tbl[16] = mk(0, 0,  0,  0, 0,  0,           1, 0, 1, 1, 1, 32'h99,       32'h10C);
        tbl[17] = mk(0, 0,  0,  0, 0,  0,           1, 0, 1, 1, 1, 32'h10D,      32'h10E);
        tbl[18] = mk(0, 0,  0,  0, 0,  0,           1, 0, 1, 1, 0, 0,            0);
        tbl[19] = mk(1, 0,  0,  1, 0,  32'hFFFF,    1, 0, 1, 1, 0, 0,            0);
        tbl[20] = mk(0, 0,  0,  0, 0,  0,           1, 0, 0, 0, 0, 0,            0);
        tbl[21] = mk(0, 0,  0,  0, 0,  0,           1, 0, 1, 1, 1, 0,            0);
        tbl[22] = mk(1, 1,  2,  0, 0,  0,           0, 0, 1, 1, 0, 0,            0);
        tbl[23] = mk(1, 3,  4,  0, 0,  0,           0, 0, 1, 1, 0, 0,            0);
        tbl[24] = mk(1, 5,  6,  0, 0,  0,           0, 1, 1, 1, 1, 32'h101,      32'h102);
        tbl[25] = mk(0, 0,  0,  0, 0,  0,           0, 0, 1, 1, 0, 0,            0);
        tbl[26] = mk(0, 0,  0,  0, 0,  0,           1, 0, 1, 1, 0, 0,            0);

        apply(idle);
        ra1 = 5'd17; ra2 = 5'd9;
        rst_n = 1'b0; preload = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_op_a", op_a, 32'd0);
        chk("rst_op_b", op_b, 32'd0);
        chk("rst_out_ra", {22'b0, out_ra1, out_ra2}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_rf_ra", {22'b0, rf_ra1, rf_ra2}, {22'b0, 5'd17, 5'd9});
        preload = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            apply(tbl[i]);
            step(1'b1, tbl[i]);
        end

        // Reset asserted with both stages occupied.
        apply(mk(1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(1'b0, idle);
        apply(mk(1, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(1'b0, idle);
        chk("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_op", op_a | op_b, 32'd0);
        chk("mid_rst_out_ra", {22'b0, out_ra1, out_ra2}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_rf_ra", {27'b0, rf_ra1}, {27'b0, ra1});
        ms1_v = 1'b0; mo_v = 1'b0;
        apply(idle);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) step(1'b0, idle);

        for (int n = 0; n < 3000; n++) begin
            rv = idle;
            rv.iv   = ($urandom_range(0, 3) != 0);
            rv.a1   = 5'($urandom_range(0, 7));
            rv.a2   = 5'($urandom_range(0, 7));
            rv.we   = ($urandom_range(0, 1) == 1);
            rv.wa   = 5'($urandom_range(0, 7));
            rv.wd   = $urandom;
            rv.xwe  = ($urandom_range(0, 2) == 0);
            rv.xwa  = 5'($urandom_range(0, 7));
            rv.xwd  = $urandom;
            rv.ordy = ($urandom_range(0, 9) < 7);
            rv.fl   = ($urandom_range(0, 31) == 0);
            apply(rv);
            step(1'b0, rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
